// File: rtl/shift_logic_pkg.sv
// Shared opcode/state enums for the sequential shift/logic unit.
// Rotate support follows SEQ_SHIFT_LOGIC_ROTATE_EN.
package shift_logic_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_XOR = 3'd2,
      OP_NOT = 3'd3,
      OP_LSL = 3'd4,
      OP_LSR = 3'd5,
      OP_ASR = 3'd6,
      OP_ROL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Opcodes that take the one-bit-per-cycle EXEC path
   function automatic logic is_seq_op(input op_e op);
      case (op)
         OP_LSL, OP_LSR, OP_ASR: is_seq_op = 1'b1;
`ifdef SEQ_SHIFT_LOGIC_ROTATE_EN
         OP_ROL:                 is_seq_op = 1'b1;
`endif
         default:                is_seq_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate stage; o_bit is the bit that leaves the word.
// ROL is only present when SEQ_SHIFT_LOGIC_ROTATE_EN is defined.
module shift_step
   import shift_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_value,
   output logic             o_bit
);

   always_comb begin
      o_value = i_value;
      o_bit   = 1'b0;
      case (op_e'(i_op))
         OP_LSL: begin
            o_value = {i_value[WIDTH-2:0], 1'b0};
            o_bit   = i_value[WIDTH-1];
         end
         OP_LSR: begin
            o_value = {1'b0, i_value[WIDTH-1:1]};
            o_bit   = i_value[0];
         end
         OP_ASR: begin
            o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
            o_bit   = i_value[0];
         end
`ifdef SEQ_SHIFT_LOGIC_ROTATE_EN
         OP_ROL: begin
            o_value = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
            o_bit   = i_value[WIDTH-1];
         end
`endif
         default: begin
            o_value = i_value;
            o_bit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_shift_logic_unit.sv
// Multi-cycle logic/shift unit: one-cycle bitwise ops, shifts at one bit per cycle.
// Define SEQ_SHIFT_LOGIC_ROTATE_EN to make op 111 a rotate-left; otherwise it passes a through.
module seq_shift_logic_unit
   import shift_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             busy
);

   state_e           r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_val;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_in_ready;

   logic [SHW-1:0]   w_n;
   logic             w_seq;
   logic [WIDTH-1:0] w_imm_res;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_bit;

   assign w_n   = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;
   assign w_seq = is_seq_op(op_e'(op));

   // Single-cycle result: logic ops, zero-length shifts and the disabled rotate all land here
   always_comb begin
      w_imm_res = a;
      case (op_e'(op))
         OP_AND:  w_imm_res = a & b;
         OP_OR:   w_imm_res = a | b;
         OP_XOR:  w_imm_res = a ^ b;
         OP_NOT:  w_imm_res = ~a;
         default: w_imm_res = a;
      endcase
   end

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_value (r_val),
      .i_op    (r_op),
      .o_value (w_step_val),
      .o_bit   (w_step_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_op        <= 3'd0;
         r_val       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_op       <= op;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  if (w_seq && (w_n != '0)) begin
                     r_val   <= a;
                     r_cnt   <= w_n;
                     r_state <= EXEC;
                  end else begin
                     r_result    <= w_imm_res;
                     r_carry     <= 1'b0;
                     r_zero      <= (w_imm_res == '0);
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            EXEC: begin
               r_val <= w_step_val;
               r_cnt <= r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  r_result    <= w_step_val;
                  r_carry     <= w_step_bit;
                  r_zero      <= (w_step_val == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign busy      = r_busy;

endmodule
